// File: rtl/data_mem_port_if.sv
// CPU-side request/response channel and RAM port A signals for data_mem_port.
// The master side is the CPU memory stage together with the RAM, which returns mem_q.
interface data_mem_port_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   logic [ADDR_W-3:0] mem_address;
   logic [31:0]       mem_data;
   logic [3:0]        mem_byteena;
   logic              mem_wren;
   logic [31:0]       mem_q;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output resp_ready, mem_q,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_address, mem_data, mem_byteena, mem_wren
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  resp_ready, mem_q,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_address, mem_data, mem_byteena, mem_wren
   );
endinterface

// File: rtl/data_mem_port.sv
// Load/store adapter between the CPU memory stage and a word-addressed,
// byte-enabled RAM with a registered read address.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no response pending
// RESP  | response pending on the resp channel
module data_mem_port #(
   parameter int ADDR_W = 32
) (
   input logic           clock,
   input logic           reset,
   data_mem_port_if.slave bus
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-3:0] held_q, held_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [1:0]        lane_q, lane_d;
   logic              err_q, err_d;

   logic              req_ready;
   logic              accept;
   logic              req_err;
   logic              mem_wren;
   logic [31:0]       mem_data;
   logic [3:0]        mem_byteena;
   logic [ADDR_W-3:0] mem_address;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic [31:0]       q_shift;
   logic [7:0]        q_byte;
   logic [15:0]       q_half;

   // Request acceptance, alignment check and RAM port drive. mem_address falls
   // back to the held word so mem_q stays put while a response is stalled.
   always_comb begin
      req_ready   = !reset && (state_q == IDLE || bus.resp_ready);
      accept      = bus.req_valid && req_ready;
      unique case (bus.req_size)
         2'b01:   req_err = bus.req_addr[0];
         2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
         2'b11:   req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
      mem_address = accept ? bus.req_addr[ADDR_W-1:2] : held_q;
      mem_wren    = accept && bus.req_we && !req_err;
      mem_data    = 32'h0;
      mem_byteena = 4'b0000;
      if (mem_wren) begin
         unique case (bus.req_size)
            2'b00: begin
               mem_data    = {4{bus.req_wdata[7:0]}};
               mem_byteena = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
               mem_data    = {2{bus.req_wdata[15:0]}};
               mem_byteena = 4'b0011 << bus.req_addr[1:0];
            end
            default: begin
               mem_data    = bus.req_wdata;
               mem_byteena = 4'b1111;
            end
         endcase
      end
   end

   // Next state and capture of the request fields needed to format the response.
   always_comb begin
      state_d  = state_q;
      held_d   = held_q;
      we_d     = we_q;
      size_d   = size_q;
      signed_d = signed_q;
      lane_d   = lane_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: if (accept) state_d = RESP;
         RESP: if (!accept && bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         held_d   = bus.req_addr[ADDR_W-1:2];
         we_d     = bus.req_we;
         size_d   = bus.req_size;
         signed_d = bus.req_signed;
         lane_d   = bus.req_addr[1:0];
         err_d    = req_err;
      end
   end

   // State and captured request fields.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         held_q   <= '0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         lane_q   <= 2'b00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         held_q   <= held_d;
         we_q     <= we_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         lane_q   <= lane_d;
         err_q    <= err_d;
      end
   end

   // Load formatting: pick the lane from mem_q and extend. Stores and errors read as zero.
   always_comb begin
      resp_valid = (state_q == RESP);
      q_shift    = bus.mem_q >> {lane_q, 3'b000};
      q_byte     = q_shift[7:0];
      q_half     = lane_q[1] ? bus.mem_q[31:16] : bus.mem_q[15:0];
      resp_rdata = 32'h0;
      if (resp_valid && !we_q && !err_q) begin
         unique case (size_q)
            2'b00:   resp_rdata = {{24{signed_q & q_byte[7]}}, q_byte};
            2'b01:   resp_rdata = {{16{signed_q & q_half[15]}}, q_half};
            2'b10:   resp_rdata = bus.mem_q;
            default: resp_rdata = 32'h0;
         endcase
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.resp_valid  = resp_valid;
   assign bus.resp_rdata  = resp_rdata;
   assign bus.resp_err    = resp_valid && err_q;
   assign bus.mem_address = mem_address;
   assign bus.mem_data    = mem_data;
   assign bus.mem_byteena = mem_byteena;
   assign bus.mem_wren    = mem_wren;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: a pipelined vector table plus hand-written
// back-pressure and mid-operation reset sequences against a small RAM model.
module tb_data_mem_port;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   data_mem_port_if #(.ADDR_W(32)) bus ();

   data_mem_port #(.ADDR_W(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // RAM model: byte-enabled write and registered read address, q from current contents.
   logic [31:0] ram [0:255];
   logic [29:0] ram_addr_q = '0;
   logic        ram_init_done = 1'b0;

   always @(posedge clock) begin
      if (!ram_init_done) begin
         for (int k = 0; k < 256; k++) ram[k] <= 32'h0;
         ram[8'h80]    <= 32'h13579BDF;
         ram_init_done <= 1'b1;
      end else if (bus.mem_wren) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_byteena[b]) ram[bus.mem_address[7:0]][8*b +: 8] <= bus.mem_data[8*b +: 8];
      end
      ram_addr_q <= bus.mem_address;
   end

   assign bus.mem_q = ram[ram_addr_q[7:0]];

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_wren;
      logic [3:0]  exp_be;
      logic [31:0] exp_data;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 18;
   vec_t vt [NV];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      //          we    size   sgn   addr       wdata         wren  be     data          rdata         err
      vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h00000080, 1'b1, 4'h8, 32'h80808080, 32'h00000000, 1'b0};
      vt[3]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        1'b0, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0};
      vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        1'b0, 4'h0, 32'h0,        32'h00000080, 1'b0};
      vt[5]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h00008001, 1'b1, 4'hC, 32'h80018001, 32'h00000000, 1'b0};
      vt[6]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        1'b0, 4'h0, 32'h0,        32'hFFFF8001, 1'b0};
      vt[7]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 4'h0, 32'h0,        32'h8001BEEF, 1'b0};
      vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        1'b0, 4'h0, 32'h0,        32'h00000000, 1'b1};
      vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h105, 32'h00001234, 1'b0, 4'h0, 32'h0,        32'h00000000, 1'b1};
      vt[10] = '{1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h0,        32'h00000000, 1'b1};
      vt[11] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 4'h0, 32'h0,        32'h8001BEEF, 1'b0};
      vt[12] = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        1'b0, 4'h0, 32'h0,        32'h00000000, 1'b0};
      vt[13] = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0000BEEF, 1'b0};
      vt[14] = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        1'b0, 4'h0, 32'h0,        32'hFFFFFFBE, 1'b0};
      vt[15] = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0,        1'b0, 4'h0, 32'h0,        32'hFFFFBEEF, 1'b0};
      vt[16] = '{1'b1, 2'd0, 1'b0, 32'h100, 32'h0000007F, 1'b1, 4'h1, 32'h7F7F7F7F, 32'h00000000, 1'b0};
      vt[17] = '{1'b0, 2'd0, 1'b1, 32'h100, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0000007F, 1'b0};

      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.resp_ready = 1'b1;

      #2;
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_resp_err",   {31'h0, bus.resp_err},   32'h0);
      chk("rst_resp_rdata", bus.resp_rdata,          32'h0);
      chk("rst_req_ready",  {31'h0, bus.req_ready},  32'h0);
      chk("rst_mem_wren",   {31'h0, bus.mem_wren},   32'h0);

      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      chk("post_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("post_rst_mem_addr",  {2'b0, bus.mem_address}, 32'h0);
      @(posedge clock);
      #1;

      // Pipelined table: request i is driven while the response of i-1 is checked.
      for (int i = 0; i < NV; i++) begin
         bus.req_valid  = 1'b1;
         bus.req_we     = vt[i].we;
         bus.req_size   = vt[i].size;
         bus.req_signed = vt[i].sgn;
         bus.req_addr   = vt[i].addr;
         bus.req_wdata  = vt[i].wdata;
         #1;
         chk($sformatf("v%0d_req_ready", i), {31'h0, bus.req_ready},   32'h1);
         chk($sformatf("v%0d_mem_addr", i),  {2'b0, bus.mem_address},  {2'b0, vt[i].addr[31:2]});
         chk($sformatf("v%0d_mem_wren", i),  {31'h0, bus.mem_wren},    {31'h0, vt[i].exp_wren});
         chk($sformatf("v%0d_mem_be", i),    {28'h0, bus.mem_byteena}, {28'h0, vt[i].exp_be});
         chk($sformatf("v%0d_mem_data", i),  bus.mem_data,             vt[i].exp_data);
         if (i == 0) begin
            chk("v0_prev_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
         end else begin
            chk($sformatf("v%0d_resp_valid", i-1), {31'h0, bus.resp_valid}, 32'h1);
            chk($sformatf("v%0d_resp_err", i-1),   {31'h0, bus.resp_err},   {31'h0, vt[i-1].exp_err});
            chk($sformatf("v%0d_resp_rdata", i-1), bus.resp_rdata,          vt[i-1].exp_rdata);
         end
         @(posedge clock);
         #1;
      end
      bus.req_valid = 1'b0;
      #1;
      chk("last_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("last_resp_rdata", bus.resp_rdata,          vt[NV-1].exp_rdata);
      chk("ram_word_41",     ram[8'h41],              32'h0);
      @(posedge clock);
      #1;
      chk("idle_resp_valid", {31'h0, bus.resp_valid}, 32'h0);

      // Back-pressure: response held for 3 cycles while another address waits.
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd2;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h100;
      #1;
      chk("bp_first_ready", {31'h0, bus.req_ready}, 32'h1);
      @(posedge clock);
      #1;
      bus.req_addr = 32'h200;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d_req_ready", k), {31'h0, bus.req_ready},  32'h0);
         chk($sformatf("bp%0d_mem_addr", k),  {2'b0, bus.mem_address}, 32'h40);
         chk($sformatf("bp%0d_resp_valid", k), {31'h0, bus.resp_valid}, 32'h1);
         chk($sformatf("bp%0d_resp_rdata", k), bus.resp_rdata,          32'h8001BE7F);
         @(posedge clock);
         #1;
      end
      bus.resp_ready = 1'b1;
      #1;
      chk("bp_rel_req_ready", {31'h0, bus.req_ready},  32'h1);
      chk("bp_rel_mem_addr",  {2'b0, bus.mem_address}, 32'h80);
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      #1;
      chk("bp_next_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("bp_next_resp_rdata", bus.resp_rdata,          32'h13579BDF);
      @(posedge clock);
      #1;
      chk("bp_idle_resp_valid", {31'h0, bus.resp_valid}, 32'h0);

      // Reset while a response is pending and a store is presented.
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h100;
      @(posedge clock);
      #1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = 32'h104;
      bus.req_wdata = 32'h55AA55AA;
      #1;
      chk("mr_pre_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
      reset = 1'b1;
      #1;
      chk("mr_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("mr_mem_wren",   {31'h0, bus.mem_wren},   32'h0);
      chk("mr_req_ready",  {31'h0, bus.req_ready},  32'h0);
      chk("mr_resp_rdata", bus.resp_rdata,          32'h0);
      @(posedge clock);
      #1;
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk("mr_after_req_ready",  {31'h0, bus.req_ready},  32'h1);
      chk("mr_after_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("mr_ram_word_41",      ram[8'h41],              32'h0);
      chk("mr_ram_word_40",      ram[8'h40],              32'h8001BE7F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
